// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT pipeline.
// Holds the stage state encodings, the sample widths and the complex sample type.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FIRST   = 2'b01,
        SECOND  = 2'b10,
        WAITING = 2'b11
    } sdf_state_t;

    localparam int DW = 17;
    localparam int AW = 16;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sdf_delay_ram.sv
// Feedback delay storage for one SDF stage.
// Reads combinationally at addr and writes synchronously at addr when we is high.
module sdf_delay_ram
    import fft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 34,
    parameter int ABITS = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sdf_r2_delay_ctrl.sv
// Sequencer and feedback delay line for one radix-2 SDF FFT stage.
// Optional sticky overflow output ovf is built when SDF_OVF_FLAG_EN is defined.
module sdf_r2_delay_ctrl
    import fft_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = fft_pkg::DW,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [1:0]           state,
    input  logic signed [DW-1:0] sr_r,
    input  logic signed [DW-1:0] sr_i,
    output logic signed [DW-1:0] b_r,
    output logic signed [DW-1:0] b_i,
`ifdef SDF_OVF_FLAG_EN
    output logic                 ovf,
`endif
    output logic                 out_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sdf_state_t      st, st_n, cur;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   ptr;
    logic            acc, adv, last, show_b;
    logic [2*DW-1:0] rd;

    // IDLE already presents WAITING when a sample arrives so the butterfly
    // produces a real SR for the sample stored in that same cycle.
    assign cur      = (st == IDLE && in_valid) ? WAITING : st;
    assign state    = cur;
    assign in_ready = (st != SECOND);
    assign acc      = in_valid & in_ready;
    assign last     = (cnt == CW'(DEPTH - 1));
    assign show_b   = (cur == FIRST) || (cur == SECOND);

    always_comb begin
        adv = 1'b0;
        case (cur)
            WAITING, FIRST: adv = acc;
            SECOND:         adv = 1'b1;
            default:        adv = 1'b0;
        endcase
    end

    always_comb begin
        st_n  = cur;
        cnt_n = cnt;
        if (adv) begin
            if (last) begin
                cnt_n = '0;
                case (cur)
                    WAITING: st_n = FIRST;
                    FIRST:   st_n = SECOND;
                    SECOND:  st_n = in_valid ? WAITING : IDLE;
                    default: st_n = IDLE;
                endcase
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
            ptr <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
            if (adv) begin
                ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
            end
        end
    end

    sdf_delay_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DW),
        .ABITS (PW)
    ) u_ram (
        .clk   (clk),
        .we    (adv),
        .addr  (ptr),
        .wdata ({sr_r, sr_i}),
        .rdata (rd)
    );

    assign b_r       = show_b ? $signed(rd[2*DW-1:DW]) : '0;
    assign b_i       = show_b ? $signed(rd[DW-1:0])    : '0;
    assign out_valid = adv & show_b;

`ifdef SDF_OVF_FLAG_EN
    // True when the value needs all DW bits, i.e. it will not fit the next stage.
    function automatic logic wide_val(input logic signed [DW-1:0] v);
        return v[DW-1] ^ v[DW-2];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (adv && (wide_val(sr_r) || wide_val(sr_i))) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sdf_r2_delay_ctrl.sv
// Directed bench for sdf_r2_delay_ctrl: DEPTH=4 frames with a delay-line scoreboard, plus a DEPTH=1 instance.
// Overflow flag checks are included when SDF_OVF_FLAG_EN is defined.
module tb_sdf_r2_delay_ctrl;

    localparam int DW = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 in_valid, in_ready, out_valid;
    logic [1:0]           state;
    logic signed [DW-1:0] sr_r, sr_i, b_r, b_i;
`ifdef SDF_OVF_FLAG_EN
    logic                 ovf;
`endif

    logic                 in_valid1, in_ready1, out_valid1;
    logic [1:0]           state1;
    logic signed [DW-1:0] sr1_r, sr1_i, b1_r, b1_i;
`ifdef SDF_OVF_FLAG_EN
    logic                 ovf1;
`endif

    sdf_r2_delay_ctrl #(.DEPTH(4), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state),
        .sr_r      (sr_r),
        .sr_i      (sr_i),
        .b_r       (b_r),
        .b_i       (b_i),
`ifdef SDF_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    sdf_r2_delay_ctrl #(.DEPTH(1), .DW(DW)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .state     (state1),
        .sr_r      (sr1_r),
        .sr_i      (sr1_i),
        .b_r       (b1_r),
        .b_i       (b1_i),
`ifdef SDF_OVF_FLAG_EN
        .ovf       (ovf1),
`endif
        .out_valid (out_valid1)
    );

    int checks = 0;
    int errors = 0;
    int ovcnt  = 0;
    int last_b = 0;
    int q[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of the DEPTH=4 instance; the scoreboard models the delay line
    task automatic step(input bit r, input bit iv, input int sr, input int est,
                        input bit erdy, input bit eov);
        int  eb;
        bit  adv;
        rst      = r;
        in_valid = iv;
        sr_r     = DW'(sr);
        sr_i     = DW'(-sr);
        @(negedge clk);
        chk("state", state, est);
        chk("in_ready", in_ready, erdy);
        chk("out_valid", out_valid, eov);
        eb = ((est == 1 || est == 2) && q.size() > 0) ? q[0] : 0;
        chk("b_r", b_r, eb);
        chk("b_i", b_i, -eb);
        last_b = b_r;
        if (out_valid === 1'b1) ovcnt++;
        adv = (est == 3 || est == 1) ? (iv & erdy) : (est == 2);
        if (adv) begin
            if (q.size() == 4) void'(q.pop_front());
            q.push_back(sr);
        end
        @(posedge clk);
        #1;
        if (r) q.delete();
    endtask

    task automatic frame(input int w0, input bit gap);
        int start;
        start = ovcnt;
        for (int k = 0; k < 4; k++) step(0, 1, w0 * (k + 1), 3, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 100 + w0 + k, 1, 1, 1);
            if (gap && k == 1) begin
                int hold;
                hold = last_b;
                for (int g = 0; g < 3; g++) begin
                    step(0, 0, 55, 1, 1, 0);
                    chk("stall_b_hold", last_b, q[0]);
                end
                hold = hold;
            end
        end
        for (int k = 0; k < 4; k++) step(0, 0, 200 + k, 2, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("frame_outputs", ovcnt - start, 8);
    endtask

    task automatic step1(input bit iv, input int sr, input int est, input bit eov, input int eb);
        in_valid1 = iv;
        sr1_r     = DW'(sr);
        sr1_i     = DW'(sr + 1);
        @(negedge clk);
        chk("d1_state", state1, est);
        chk("d1_out_valid", out_valid1, eov);
        chk("d1_b_r", b1_r, eb);
        chk("d1_b_i", b1_i, (eb == 0) ? 0 : eb + 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sr_r      = '0;
        sr_i      = '0;
        in_valid1 = 1'b0;
        sr1_r     = '0;
        sr1_i     = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        step(0, 0, 0, 0, 1, 0);
        chk("d1_reset_state", state1, 0);

        // test 1: continuous frame
        frame(1, 0);

        // test 2: explicit WAITING values reappear in FIRST
        for (int k = 0; k < 4; k++) step(0, 1, 10 * (k + 1), 3, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 300 + k, 1, 1, 1);
            chk("t2_first_b", last_b, 10 * (k + 1));
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 400 + k, 2, 0, 1);
            chk("t2_second_b", last_b, 300 + k);
        end
        step(0, 0, 0, 0, 1, 0);

        // test 3: gap in FIRST
        frame(7, 1);

        // test 4: reset in the 2nd SECOND cycle, then a clean frame
        for (int k = 0; k < 4; k++) step(0, 1, 3 * k + 1, 3, 1, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 500 + k, 1, 1, 1);
        step(0, 0, 600, 2, 0, 1);
        step(1, 0, 601, 2, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        frame(2, 0);

        // test 5: DEPTH=1
        step1(1, 15, 3, 0, 0);
        step1(1, 21, 1, 1, 15);
        step1(1, 99, 2, 1, 21);
        step1(1, 15, 3, 0, 0);
        step1(1, 21, 1, 1, 15);
        step1(0, 98, 2, 1, 21);
        step1(0, 0, 0, 0, 0);

`ifdef SDF_OVF_FLAG_EN
        // test 6: sticky overflow flag
        chk("ovf_idle", ovf, 0);
        step(0, 1, -1, 3, 1, 0);
        chk("ovf_minus1", ovf, 0);
        step(0, 1, 32768, 3, 1, 0);
        chk("ovf_set", ovf, 1);
        step(0, 1, 5, 3, 1, 0);
        chk("ovf_sticky", ovf, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk("ovf_rst", ovf, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
